// File: rtl/mxrx_check_if.sv
// Receive-side strobe bundle from the Manchester receiver to mxrx_check.
// master drives the byte and strobes, slave (the checker) observes them.
interface mxrx_check_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eof;
    logic       rx_error;

    modport master (output rx_data, rx_valid, rx_eof, rx_error);
    modport slave  (input  rx_data, rx_valid, rx_eof, rx_error);
endinterface

// File: rtl/mxrx_check.sv
// Frame checker for the Manchester receiver: compares received bytes against a fixed table
// and keeps saturating frame/byte statistics. Define MXRX_CHECK_ERRLOG_EN for the first-error log.
module mxrx_check #(
    parameter int MEM_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    mxrx_check_if.slave rx,
    input  logic [5:0]  length_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        last_frame_ok_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] good_count_o,
    output logic [15:0] byte_err_count_o,
    output logic [4:0]  first_err_addr_o,
    output logic [7:0]  first_err_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(MEM_SIZE - 1);

    localparam logic [7:0] EXP_TABLE [32] = '{
        8'haa, 8'h00, 8'haa, 8'hff, 8'h55, 8'h06, 8'h07, 8'h08,
        8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
        8'h17, 8'h18, 8'h19, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24,
        8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h30, 8'h31, 8'h32
    };

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        bad_q, bad_d;
    logic [6:0]  rcnt_q, rcnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        last_ok_q, last_ok_d;

    logic byte_take;
    logic surplus;
    logic mismatch;
    logic frame_ok;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        rcnt_d      = rcnt_q;
        frame_cnt_d = frame_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_ok_d   = last_ok_q;

        byte_take = rx.rx_valid &&
                    ((state_q == ST_RECV) || ((state_q == ST_IDLE) && (length_i != '0)));
        surplus   = rcnt_q >= {1'b0, length_i};
        mismatch  = byte_take && !surplus && (rx.rx_data != EXP_TABLE[idx_q]);
        frame_ok  = !bad_q && (rcnt_q == {1'b0, length_i});

        // A byte arriving together with eof is scored before the move to DONE.
        if (byte_take) begin
            rcnt_d = (rcnt_q == '1) ? rcnt_q : rcnt_q + 7'd1;
            if (surplus) begin
                idx_d = LAST_IDX;
            end else if (idx_q != LAST_IDX) begin
                idx_d = idx_q + 5'd1;
            end
            if (surplus || mismatch) begin
                bad_d     = 1'b1;
                err_cnt_d = sat_inc16(err_cnt_q);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_take) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (rx.rx_error) bad_d = 1'b1;
                if (rx.rx_eof) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                bad_d       = 1'b0;
                rcnt_d      = '0;
                frame_cnt_d = sat_inc16(frame_cnt_q);
                if (frame_ok) good_cnt_d = sat_inc16(good_cnt_q);
                last_ok_d   = frame_ok;
            end
            default: state_d = ST_IDLE;
        endcase

        // Statistics clear takes priority over any same-cycle update; frame state is untouched.
        if (clear_i) begin
            frame_cnt_d = '0;
            good_cnt_d  = '0;
            err_cnt_d   = '0;
            last_ok_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            rcnt_q      <= '0;
            frame_cnt_q <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            last_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            rcnt_q      <= rcnt_d;
            frame_cnt_q <= frame_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_ok_q   <= last_ok_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign frame_done_o     = (state_q == ST_DONE);
    assign last_frame_ok_o  = last_ok_q;
    assign frame_count_o    = frame_cnt_q;
    assign good_count_o     = good_cnt_q;
    assign byte_err_count_o = err_cnt_q;

`ifdef MXRX_CHECK_ERRLOG_EN
    logic       log_vld_q;
    logic [4:0] log_addr_q;
    logic [7:0] log_data_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            log_vld_q  <= 1'b0;
            log_addr_q <= '0;
            log_data_q <= '0;
        end else if (mismatch && !log_vld_q) begin
            log_vld_q  <= 1'b1;
            log_addr_q <= idx_q;
            log_data_q <= rx.rx_data;
        end
    end

    assign first_err_addr_o = log_addr_q;
    assign first_err_data_o = log_data_q;
`else
    assign first_err_addr_o = '0;
    assign first_err_data_o = '0;
`endif

endmodule

// File: doc/mxrx_check.md
MXRX_CHECK -- requirements
Module: mxrx_check

Interface
REQ-001 Parameter MEM_SIZE, default 32, depth of the expected-byte table and maximum frame length.
REQ-002 clk  input  1  rising-edge clock, same clock as the Manchester receiver.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 length  input  6  expected bytes per frame (1..MEM_SIZE); 0 disables checking.
REQ-005 clear  input  1  synchronous, active-high clear of all statistics.
REQ-006 rx_data  input  8  received byte from the Manchester receiver.
REQ-007 rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
REQ-008 rx_eof  input  1  one-cycle strobe: end of frame (carrier lost).
REQ-009 rx_error  input  1  one-cycle strobe: receiver line or framing error.
REQ-010 busy  output  1  high while a frame is in progress (state RECV or DONE).
REQ-011 frame_done  output  1  one-cycle pulse at the end of every checked frame.
REQ-012 last_frame_ok  output  1  result of the most recent completed frame.
REQ-013 frame_count  output  16  frames completed, saturating.
REQ-014 good_count  output  16  frames completed with no error, saturating.
REQ-015 byte_err_count  output  16  mismatched plus surplus bytes, saturating.
REQ-016 first_err_addr  output  5  byte index of the first mismatch since clear (REQ-036).
REQ-017 first_err_data  output  8  received value of the first mismatch since clear (REQ-036).

Function
REQ-018 Expected table, index 0..31, SHALL be: aa, 00, aa, ff, 55, 06, 07, 08, 09, 10 .. 19, 20 .. 29, 30, 31, 32 (hex, BCD-style increments from index 9).
REQ-019 FSM SHALL have three states: IDLE, RECV, DONE.
REQ-020 IDLE: byte index = 0 and frame-bad flag = 0; rx_valid with length != 0 -> RECV, and that byte is checked at index 0.
REQ-021 IDLE: rx_eof, rx_error, and rx_valid with length == 0 are ignored.
REQ-022 RECV: each rx_valid compares rx_data with expected[index]; on mismatch, byte_err_count increments and the frame-bad flag sets.
REQ-023 Each checked byte SHALL increment the receive count; receive count is 7 bits and saturates at 127.
REQ-024 A byte received when receive count >= length is a surplus byte: error counted, frame marked bad, index held at MEM_SIZE-1, no table compare.
REQ-025 RECV: rx_error sets the frame-bad flag; the frame continues.
REQ-026 RECV: rx_eof -> DONE; if rx_valid occurs in the same cycle, the byte is checked first.
REQ-027 DONE SHALL last exactly one cycle, assert frame_done, then go to IDLE; rx_valid in DONE is ignored.
REQ-028 Frame OK = frame-bad flag clear AND receive count == length; a short frame is bad.
REQ-029 At the edge leaving DONE: frame_count increments; good_count increments if OK; last_frame_ok is loaded; values are visible the cycle after frame_done.
REQ-030 All counters SHALL saturate at 16'hFFFF, never wrap.
REQ-031 clear zeroes frame_count, good_count, byte_err_count, last_frame_ok and error-log outputs; it does not affect FSM state or the frame in progress.
REQ-032 If clear coincides with a counter update, clear wins.
REQ-033 length is sampled continuously; it SHALL be changed only in IDLE.

Reset
REQ-034 reset SHALL force IDLE, index 0, frame-bad 0, receive count 0, and all outputs 0, including mid-frame; reset overrides clear and every strobe.

Configuration
REQ-035 Macro MXRX_CHECK_ERRLOG_EN selects the first-error log.
REQ-036 With the macro defined: on the first mismatch after reset or clear, first_err_addr/first_err_data capture index/rx_data and hold until the next reset or clear; surplus bytes are not logged.
REQ-037 Without the macro: first_err_addr and first_err_data are constant 0 and no log registers exist.

Verification
REQ-038 length=5, bytes aa,00,aa,ff,55, then rx_eof -> frame_done pulse; then last_frame_ok=1, frame_count=1, good_count=1, byte_err_count=0.
REQ-039 length=5, bytes aa,00,ab,ff,55, eof -> last_frame_ok=0, byte_err_count=1, good_count=0; with macro, first_err_addr=2, first_err_data=ab.
REQ-040 length=3, 4 bytes aa,00,aa,00, eof -> byte_err_count=1, last_frame_ok=0; length=3, 2 bytes, eof -> last_frame_ok=0, byte_err_count unchanged.
REQ-041 length=2, rx_valid with 00 and rx_eof in the same cycle after byte aa -> frame OK, frame_done the next cycle.
REQ-042 Reset asserted after 2 of 5 bytes -> all outputs 0, busy=0; next full good frame -> good_count=1.
REQ-043 Preload frame_count=16'hFFFE, run 3 good frames -> frame_count=16'hFFFF; clear -> all counters 0.
